// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encoding, register-index width, the NOP word used by the IF/ID flush and
// ID/EX bubble muxes, and a small source/destination match helper.
package pipe_hazard_ctrl_pkg;

  // Register-file index width (32 architectural registers).
  localparam int REG_W = 5;

  // Width of the internal multi-cycle down-counter; covers MC_LAT up to 15.
  localparam int MC_CNT_W = 4;

  // All-zero instruction word: decodes as a no-op with every control bit clear.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sequencing FSM states.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } state_t;

  // True when an ID source that is actually read names the given destination.
  function automatic logic src_hits(input logic             use_src,
                                    input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst);
    return use_src && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline stages and the sequencing controller.
// The master side is the datapath (it presents ID/EX decode information and
// consumes the enables); the slave side is the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_hazard_ctrl_pkg::*;

  // Enable semantics: wpc/wpcir are level write enables sampled by the PC and
  // IF/ID registers on the same rising edge; bubble and flush_ir select the
  // NOP word into ID/EX and IF/ID on that edge. All are combinational from the
  // controller state and the current ID/EX inputs, so they are valid every
  // cycle with no separate valid/ready qualifier.
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_mc_op;
  logic             id_redirect;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [REG_W-1:0] ex_rn;

  logic             wpc;
  logic             wpcir;
  logic             bubble;
  logic             flush_ir;
  logic             mc_go;
  logic [CNT_W-1:0] stall_cycles;
  state_t           dbg_state;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_mc_op, id_redirect,
           ex_wreg, ex_m2reg, ex_rn,
    input  wpc, wpcir, bubble, flush_ir, mc_go, stall_cycles, dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_mc_op, id_redirect,
           ex_wreg, ex_m2reg, ex_rn,
    output wpc, wpcir, bubble, flush_ir, mc_go, stall_cycles, dbg_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use hazard comparator. Purely combinational so the forwarding unit can
// instantiate the same block. A load in EX whose destination is read by the
// instruction in ID cannot be forwarded in time; r0 is hardwired to zero and
// never creates a dependency.
module pipe_hazard_ctrl_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_ex_wreg,
  input  logic             i_ex_m2reg,
  input  logic [REG_W-1:0] i_ex_rn,
  output logic             o_lu_haz
);

  logic w_ex_load_wr;
  logic w_src_dep;

  // A load that really writes a non-zero register, against either used source.
  always_comb begin
    w_ex_load_wr = i_ex_m2reg && i_ex_wreg && (i_ex_rn != '0);
    w_src_dep    = src_hits(i_id_use_rs, i_id_rs, i_ex_rn) ||
                   src_hits(i_id_use_rt, i_id_rt, i_ex_rn);
    o_lu_haz     = w_ex_load_wr && w_src_dep;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage CPU. Drives the PC and IF/ID
// write enables, the ID/EX bubble select and the IF/ID flush. Stalls one cycle
// on a load-use hazard, holds a multi-cycle op in ID for MC_LAT cycles while
// the mul/div unit works, and kills the wrong-path fetch on an ID redirect.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipe_hazard_ctrl_if.slave bus
);

  // Latency is loaded into a 4-bit down-counter and must leave at least one
  // MC_BUSY cycle, so only 2..15 make sense.
  if (MC_LAT < 2 || MC_LAT > 15) begin : g_bad_mc_lat
    $error("pipe_hazard_ctrl: MC_LAT must be in 2..15");
  end

  // Cycles spent in MC_BUSY after the issue cycle in RUN.
  localparam logic [MC_CNT_W-1:0] MC_BUSY_CYC = MC_CNT_W'(MC_LAT - 1);

  state_t              r_state;
  logic [MC_CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic w_lu_haz;
  logic w_wpc;
  logic w_wpcir;
  logic w_bubble;
  logic w_flush_ir;
  logic w_mc_go;
  logic w_stall_sat;

  pipe_hazard_ctrl_hazard_cmp u_hazard_cmp (
    .i_id_rs     (bus.id_rs),
    .i_id_rt     (bus.id_rt),
    .i_id_use_rs (bus.id_use_rs),
    .i_id_use_rt (bus.id_use_rt),
    .i_ex_wreg   (bus.ex_wreg),
    .i_ex_m2reg  (bus.ex_m2reg),
    .i_ex_rn     (bus.ex_rn),
    .o_lu_haz    (w_lu_haz)
  );

  // Enables decoded from state and live ID/EX inputs; the default is the safe
  // frozen setting (hold PC and IF/ID, inject a bubble), which is also what
  // reset forces.
  always_comb begin
    w_wpc      = 1'b0;
    w_wpcir    = 1'b0;
    w_bubble   = 1'b1;
    w_flush_ir = 1'b0;
    w_mc_go    = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (w_lu_haz) begin
            // Load result not ready: hold ID, a pending redirect waits too.
            w_wpc = 1'b0;
          end else if (bus.id_mc_op) begin
            // Issue cycle counts as the first of the MC_LAT stall cycles.
            w_mc_go = 1'b1;
          end else begin
            w_wpc      = 1'b1;
            w_wpcir    = 1'b1;
            w_bubble   = 1'b0;
            w_flush_ir = bus.id_redirect;
          end
        end
        MC_BUSY: begin
          // ID is frozen; redirect and load-use inputs are not acted upon.
          w_wpc = 1'b0;
        end
        MC_DONE: begin
          // The multi-cycle op now leaves ID; its still-asserted id_mc_op is
          // not a new request, but a redirect it resolved is honoured.
          w_wpc      = 1'b1;
          w_wpcir    = 1'b1;
          w_bubble   = 1'b0;
          w_flush_ir = bus.id_redirect;
        end
        default: begin
          w_wpc = 1'b0;
        end
      endcase
    end
  end

  // Sequencing FSM with the multi-cycle latency down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_lu_haz && bus.id_mc_op) begin
            r_cnt   <= MC_BUSY_CYC;
            r_state <= MC_BUSY;
          end
        end
        MC_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == MC_CNT_W'(1)) begin
            r_state <= MC_DONE;
          end
        end
        MC_DONE: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_stall_sat = &r_stall_cycles;

  // Performance counter of cycles in which IF/ID was held; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!w_wpcir && !w_stall_sat) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.wpc          = w_wpc;
  assign bus.wpcir        = w_wpcir;
  assign bus.bubble       = w_bubble;
  assign bus.flush_ir     = w_flush_ir;
  assign bus.mc_go        = w_mc_go;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances share one stimulus stream, one
// with the default 16-bit stall counter and one with a 4-bit counter so that
// saturation is reachable. A behavioural model tracks how many frozen cycles
// remain and whether the op is leaving ID, and predicts every output.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int MC_LAT  = 4;
  localparam int CNT_A_W = 16;
  localparam int CNT_B_W = 4;
  localparam int MAX_A   = (1 << CNT_A_W) - 1;
  localparam int MAX_B   = (1 << CNT_B_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [4:0] id_rs, id_rt, ex_rn;
  logic       id_use_rs, id_use_rt, id_mc_op, id_redirect, ex_wreg, ex_m2reg;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_A_W)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(CNT_B_W)) ifb ();

  assign ifa.id_rs = id_rs;           assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;           assign ifb.id_rt = id_rt;
  assign ifa.id_use_rs = id_use_rs;   assign ifb.id_use_rs = id_use_rs;
  assign ifa.id_use_rt = id_use_rt;   assign ifb.id_use_rt = id_use_rt;
  assign ifa.id_mc_op = id_mc_op;     assign ifb.id_mc_op = id_mc_op;
  assign ifa.id_redirect = id_redirect; assign ifb.id_redirect = id_redirect;
  assign ifa.ex_wreg = ex_wreg;       assign ifb.ex_wreg = ex_wreg;
  assign ifa.ex_m2reg = ex_m2reg;     assign ifb.ex_m2reg = ex_m2reg;
  assign ifa.ex_rn = ex_rn;           assign ifb.ex_rn = ex_rn;

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_A_W)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_B_W)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  int go_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_busy_left = 0;  // frozen cycles still owed after the issue cycle
  bit m_done      = 0;  // next cycle the multi-cycle op leaves ID
  int m_cnt_a     = 0;
  int m_cnt_b     = 0;

  function automatic bit model_lu();
    bit dep;
    dep = (id_use_rs && id_rs == ex_rn) || (id_use_rt && id_rt == ex_rn);
    return ex_m2reg && ex_wreg && (ex_rn != 0) && dep;
  endfunction

  // Expected {wpc, wpcir, bubble, flush_ir, mc_go}.
  function automatic logic [4:0] model_out();
    if (rst)             return 5'b00100;
    if (m_busy_left > 0) return 5'b00100;
    if (m_done)          return {1'b1, 1'b1, 1'b0, id_redirect, 1'b0};
    if (model_lu())      return 5'b00100;
    if (id_mc_op)        return 5'b00101;
    return {1'b1, 1'b1, 1'b0, id_redirect, 1'b0};
  endfunction

  task automatic model_clear();
    m_busy_left = 0;
    m_done      = 0;
    m_cnt_a     = 0;
    m_cnt_b     = 0;
  endtask

  task automatic model_update(input logic [4:0] e);
    if (rst) begin
      model_clear();
    end else begin
      if (!e[3]) begin
        if (m_cnt_a < MAX_A) m_cnt_a++;
        if (m_cnt_b < MAX_B) m_cnt_b++;
      end
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_done = 1;
      end else if (m_done) begin
        m_done = 0;
      end else if (e[0]) begin
        m_busy_left = MC_LAT - 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rn = 0;
    id_use_rs = 0; id_use_rt = 0; id_mc_op = 0; id_redirect = 0;
    ex_wreg = 0; ex_m2reg = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rn);
    ex_m2reg = 1; ex_wreg = 1; ex_rn = rn;
    id_use_rs = 1; id_rs = rn;
  endtask

  // One clock: compare at the falling edge, advance the model on the rising one.
  task automatic step();
    logic [4:0] e;
    @(negedge clk);
    if (rst) model_clear();
    e = model_out();
    check("ctl_a", {27'b0, ifa.wpc, ifa.wpcir, ifa.bubble, ifa.flush_ir, ifa.mc_go}, {27'b0, e});
    check("ctl_b", {27'b0, ifb.wpc, ifb.wpcir, ifb.bubble, ifb.flush_ir, ifb.mc_go}, {27'b0, e});
    check("cnt_a", 32'(ifa.stall_cycles), 32'(m_cnt_a));
    check("cnt_b", 32'(ifb.stall_cycles), 32'(m_cnt_b));
    if (ifa.mc_go) go_seen++;
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_inputs();
    rst = 1;
    #1;
    step();
    step();
    check("rst_state", 32'(ifa.dbg_state), 32'(RUN));
    rst = 0;
    step();

    // Load-use on rs: one stall, then free flow.
    set_load_use(5'd5);
    step();
    clear_inputs();
    step();
    check("lu_count", 32'(ifa.stall_cycles), 32'd1);

    // Same pattern on r0 never stalls.
    set_load_use(5'd0);
    step();
    clear_inputs();
    check("r0_count", 32'(ifa.stall_cycles), 32'd1);

    // Multi-cycle op held in ID through issue, busy and done.
    go_seen  = 0;
    id_mc_op = 1;
    for (int i = 0; i < MC_LAT + 1; i++) step();
    id_mc_op = 0;
    check("mc_go_pulses", 32'(go_seen), 32'd1);
    check("mc_count", 32'(ifa.stall_cycles), 32'd5);
    step();

    // Redirect coincident with load-use is deferred one cycle.
    set_load_use(5'd7);
    id_redirect = 1;
    step();
    clear_inputs();
    id_redirect = 1;
    step();
    clear_inputs();
    check("redir_count", 32'(ifa.stall_cycles), 32'd6);

    // Asynchronous reset two cycles into MC_BUSY.
    id_mc_op = 1;
    step();
    step();
    step();
    #1;
    rst = 1;
    #1;
    check("rst_async_ctl", {27'b0, ifa.wpc, ifa.wpcir, ifa.bubble, ifa.flush_ir, ifa.mc_go}, 32'b00100);
    check("rst_async_cnt", 32'(ifa.stall_cycles), 32'd0);
    check("rst_async_state", 32'(ifa.dbg_state), 32'(RUN));
    id_mc_op = 0;
    step();
    rst = 0;
    go_seen = 0;
    step();
    step();
    check("post_rst_go", 32'(go_seen), 32'd0);
    check("post_rst_cnt", 32'(ifa.stall_cycles), 32'd0);
    check("post_rst_state", 32'(ifa.dbg_state), 32'(RUN));

    // Hold a load-use hazard long enough to saturate the 4-bit counter.
    set_load_use(5'd9);
    for (int i = 0; i < 20; i++) step();
    clear_inputs();
    check("sat_b", 32'(ifb.stall_cycles), 32'd15);
    check("sat_a", 32'(ifa.stall_cycles), 32'd20);
    step();

    // Randomized traffic with small register indices to provoke dependencies.
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rn       = 5'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      id_mc_op    = ($urandom_range(0, 7) == 0);
      id_redirect = ($urandom_range(0, 3) == 0);
      ex_wreg     = 1'($urandom_range(0, 1));
      ex_m2reg    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
